bstream_decode: RTL and testbench

BSTREAM_DECODE -- requirements
Module: bstream_decode

---
 rtl/bstream_pkg.sv | 20 ++
 rtl/bstream_wincnt.sv | 45 ++++
 rtl/bstream_decode.sv | 98 +++++++++
 tb/tb_bstream_decode.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bstream_pkg.sv
// Shared types and width helpers for the bitstream decoder.
package bstream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Width of the ones counter and of the window counter: must hold 0..WIN.
   function automatic int ones_width(input int winlog);
      return winlog + 1;
   endfunction

   // Width of the decoded result: room for the signed range -WIN..+WIN.
   function automatic int result_width(input int winlog);
      return winlog + 2;
   endfunction

endpackage

// File: rtl/bstream_wincnt.sv
// Window counter for bstream_decode: counts samples taken in the current
// window and flags the cycle in which the final sample (WIN-1) is taken.
module bstream_wincnt
   import bstream_pkg::*;
#(
   parameter int WINLOG = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   localparam int              CW   = ones_width(WINLOG);
   localparam logic [CW-1:0]   LAST = CW'((1 << WINLOG) - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: a clear marks sample 0 as taken, so the count restarts at 1.
   always_comb begin
      // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CW'(1);
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge, and <= keeps all flops reading pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The sample being taken in this cycle is the last one of the window.
   assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/bstream_decode.sv
// Unary bitstream decoder: counts the ones in a window of 2^WINLOG samples
// and presents the count on a valid/ready output.
// Optional feature: define BSTREAM_DECODE_BIPOLAR_EN to report 2*ones - WIN
// as a signed two's-complement value instead of the raw ones count.
module bstream_decode
   import bstream_pkg::*;
#(
   parameter int WINLOG = 8,
   parameter int OW     = WINLOG + 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in,
   input  logic          start,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data
);

   localparam int CW = ones_width(WINLOG);

   state_e        state_q;
   logic [CW-1:0] ones_q;
   logic [CW-1:0] ones_d;
   logic [OW-1:0] out_data_q;
   logic [OW-1:0] result_d;
   logic          accept;
   logic          count_en;
   logic          last;

   // A new window may only open from IDLE or from a HOLD whose result is taken now.
   assign accept   = start && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
   assign count_en = (state_q == COUNT);

   bstream_wincnt #(
      .WINLOG (WINLOG)
   ) u_wincnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (accept),
      .en_i   (count_en),
      .last_o (last)
   );

   // Running ones count including this cycle's sample, and the result it maps to.
   always_comb begin
      ones_d = ones_q + CW'(in);
`ifdef BSTREAM_DECODE_BIPOLAR_EN
      result_d = OW'({ones_d, 1'b0}) - OW'(1 << WINLOG);
`else
      result_d = OW'(ones_d);
`endif
   end

   // Control FSM with ones accumulator and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ones_q     <= '0;
         out_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ones_q  <= CW'(in);
                  state_q <= COUNT;
               end
            end
            COUNT: begin
               ones_q <= ones_d;
               if (last) begin
                  out_data_q <= result_d;
                  state_q    <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (start) begin
                     ones_q  <= CW'(in);
                     state_q <= COUNT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q == COUNT);
   assign out_valid = (state_q == HOLD);
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_bstream_decode.sv
// Self-checking bench for bstream_decode at WINLOG=3 (WIN=8). Stimulus runs
// whole windows; expected results are queued and checked by a monitor.
module tb_bstream_decode;

   localparam int WINLOG = 3;
   localparam int WIN    = 1 << WINLOG;
   localparam int OW     = WINLOG + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          din;
   logic          start;
   logic          out_ready;
   logic          busy;
   logic          out_valid;
   logic [OW-1:0] out_data;

   int vectors    = 0;
   int miscompares = 0;

   // Expected behaviour of the current cycle, set by the stimulus.
   bit mon_en    = 1'b0;
   bit exp_busy  = 1'b0;
   bit exp_valid = 1'b0;
   bit exp_zero  = 1'b0;
   bit in_hold   = 1'b0;

   logic [OW-1:0] sb[$];

   always #5 clk = ~clk;

   bstream_decode #(
      .WINLOG (WINLOG),
      .OW     (OW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (din),
      .start     (start),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: sampled mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", 32'(busy), 32'(exp_busy));
         check("out_valid", 32'(out_valid), 32'(exp_valid));
         if (exp_zero) check("reset_data", 32'(out_data), 32'd0);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               check("out_data", 32'(out_data), 32'(sb[0]));
               if (out_ready === 1'b1) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      exp_zero = 1'b0;
   endtask

   // Decoded value of a window, from the rules: count of ones, optionally 2*ones-WIN.
   function automatic logic [OW-1:0] model(input logic [WIN-1:0] bits);
      int ones = 0;
      for (int i = 0; i < WIN; i++) ones += int'(bits[i]);
`ifdef BSTREAM_DECODE_BIPOLAR_EN
      return OW'(2 * ones - WIN);
`else
      return OW'(ones);
`endif
   endfunction

   // One window: start in the first cycle, then hold_wait stalled HOLD cycles,
   // then optionally a plain acknowledge. Without ack the bench stays in HOLD.
   task automatic run_window(input logic [WIN-1:0] bits, input int hold_wait,
                             input bit ack, input bit steady);
      sb.push_back(model(bits));
      for (int i = 0; i < WIN; i++) begin
         start     = (i == 0 || steady) ? 1'b1 : 1'($urandom);
         out_ready = (i == 0 || steady) ? 1'b1 : 1'($urandom);
         din       = bits[i];
         exp_busy  = (i != 0);
         exp_valid = (i == 0) && in_hold;
         step();
      end
      in_hold = 1'b1;
      for (int h = 0; h < hold_wait; h++) begin
         start     = 1'(h % 2);
         din       = 1'(h % 2 == 0);
         out_ready = 1'b0;
         exp_busy  = 1'b0;
         exp_valid = 1'b1;
         step();
      end
      if (ack) begin
         start     = 1'b0;
         din       = 1'($urandom);
         out_ready = 1'b1;
         exp_busy  = 1'b0;
         exp_valid = 1'b1;
         step();
         in_hold = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start     = 1'b0;
         din       = 1'($urandom);
         out_ready = 1'($urandom);
         exp_busy  = 1'b0;
         exp_valid = 1'b0;
         step();
      end
   endtask

   // Reset asserted while sample 4 of a window is being presented.
   task automatic reset_mid_count();
      for (int i = 0; i < 4; i++) begin
         start     = 1'b1;
         out_ready = 1'b1;
         din       = 1'b1;
         exp_busy  = (i != 0);
         exp_valid = 1'b0;
         step();
      end
      rst_n     = 1'b0;
      din       = 1'b1;
      exp_busy  = 1'b1;
      exp_valid = 1'b0;
      step();
      rst_n    = 1'b1;
      exp_zero = 1'b1;
   endtask

   // Reset asserted while a finished result waits in HOLD.
   task automatic reset_in_hold(input logic [WIN-1:0] bits);
      run_window(bits, 1, 1'b0, 1'b0);
      rst_n     = 1'b0;
      start     = 1'b1;
      out_ready = 1'b0;
      exp_busy  = 1'b0;
      exp_valid = 1'b1;
      step();
      rst_n = 1'b1;
      void'(sb.pop_back());
      in_hold  = 1'b0;
      exp_zero = 1'b1;
   endtask

   initial begin
      logic [WIN-1:0] ones_pat;
      logic [WIN-1:0] zero_pat;
      logic [WIN-1:0] alt_pat;
      ones_pat = '1;
      zero_pat = '0;
      for (int i = 0; i < WIN; i++) alt_pat[i] = (i % 2 == 0);

      rst_n = 1'b0; start = 1'b0; din = 1'b0; out_ready = 1'b0;
      step();
      mon_en   = 1'b1;
      exp_zero = 1'b1;
      step();
      exp_zero = 1'b1;
      rst_n    = 1'b1;

      // Start in the very first cycle after reset release.
      run_window(ones_pat, 0, 1'b1, 1'b0);
      idle(2);
      run_window(zero_pat, 0, 1'b1, 1'b0);
      run_window(alt_pat, 0, 1'b1, 1'b0);
      idle(1);

      // Stalled consumer: result must stay put while start/in wiggle.
      run_window(ones_pat, 5, 1'b1, 1'b0);
      idle(1);

      // Back-to-back windows with start and out_ready held high.
      for (int w = 0; w < 4; w++) run_window(ones_pat, 0, 1'b0, 1'b1);
      start = 1'b0; out_ready = 1'b1; din = 1'b1; exp_busy = 1'b0; exp_valid = 1'b1;
      step();
      in_hold = 1'b0;
      idle(2);

      reset_mid_count();
      run_window(alt_pat, 0, 1'b1, 1'b0);
      idle(1);
      reset_in_hold(ones_pat);
      idle(3);
      run_window(zero_pat, 1, 1'b1, 1'b0);

      // Randomized windows, stalls and chaining.
      for (int w = 0; w < 40; w++) begin
         run_window(WIN'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
         if (!in_hold) idle(int'($urandom_range(0, 2)));
      end
      if (in_hold) begin
         start = 1'b0; out_ready = 1'b1; din = 1'b0; exp_busy = 1'b0; exp_valid = 1'b1;
         step();
         in_hold = 1'b0;
      end
      idle(3);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
